// File: rtl/fbuf_sched_pkg.sv
// Shared definitions for the frame-buffer scheduler: channel FSM encoding
// and the buffer-index-to-address helpers.
package fbuf_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2
    } chan_state_t;

    // Computed at 64 bits; callers truncate to their address width.
    function automatic logic [63:0] buf_addr(input logic [63:0] base,
                                             input logic [63:0] size,
                                             input logic [1:0]  idx);
        return base + size * {62'd0, idx};
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] idx,
                                            input logic [1:0] last);
        return (idx == last) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/fbuf_chan_fsm.sv
// One transfer channel: IDLE -> REQ -> RUN -> IDLE, with accept/drop strobes
// for the incoming frame sync.
module fbuf_chan_fsm
    import fbuf_sched_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        fs,
    input  logic        en,
    input  logic        ack,
    input  logic        done,
    output logic        req,
    output chan_state_t state,
    output logic        accept,
    output logic        drop
);

    chan_state_t state_q, state_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge I_clk) begin
        if (I_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block is defaulted first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fs && en) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    drop = fs;
                end
            end
            ST_REQ: begin
                drop = fs;
                if (ack) state_d = ST_RUN;
            end
            ST_RUN: begin
                drop = fs;
                if (done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req   = (state_q == ST_REQ);
    assign state = state_q;

endmodule

// File: rtl/fbuf_sched.sv
// Frame-buffer scheduler: picks write/read buffers so the writer never lands
// on the buffer the reader holds, and publishes their base addresses.
module fbuf_sched
    import fbuf_sched_pkg::*;
#(
    parameter int                 BUF_NUM  = 3,
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  BUF_BASE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0]  BUF_SIZE = 32'h0080_0000
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_wfs,
    input  logic              I_rfs,
    input  logic              I_wack,
    input  logic              I_rack,
    input  logic              I_wdone,
    input  logic              I_rdone,
    output logic              O_wreq,
    output logic              O_rreq,
    output logic [1:0]        O_wbuf,
    output logic [1:0]        O_rbuf,
    output logic [ADDR_W-1:0] O_waddr,
    output logic [ADDR_W-1:0] O_raddr,
    output logic [7:0]        O_wdrop_cnt,
    output logic [7:0]        O_rrep_cnt
);

    localparam logic [1:0] LAST_IDX = 2'(BUF_NUM - 1);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] idx);
        logic [63:0] full;
        full = buf_addr(64'(BUF_BASE), 64'(BUF_SIZE), idx);
        return full[ADDR_W-1:0];
    endfunction

    chan_state_t w_state, r_state;
    logic        w_accept, w_drop, r_accept, r_drop;
    logic        wdone_eff, r_en;
    logic [1:0]  wbuf_q, rbuf_q, last_done_q;
    logic        ld_valid_q, hold_q;
    logic [7:0]  wdrop_q, rrep_q;
    logic [1:0]  rsel, rbuf_eff, wcand, wsel;
    logic        hold_eff;

    // A completion only counts while the write channel is actually running;
    // it is forwarded so a same-cycle read sync can pick the fresh frame.
    assign wdone_eff = I_wdone && (w_state == ST_RUN);
    assign r_en      = ld_valid_q || wdone_eff;
    assign rsel      = wdone_eff ? wbuf_q : last_done_q;

    // Read selection resolves first; the write skip rule sees its result.
    assign hold_eff  = hold_q || r_accept;
    assign rbuf_eff  = r_accept ? rsel : rbuf_q;
    assign wcand     = next_idx(wbuf_q, LAST_IDX);
    assign wsel      = (hold_eff && wcand == rbuf_eff) ? next_idx(wcand, LAST_IDX) : wcand;

    fbuf_chan_fsm u_wr (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .fs     (I_wfs),
        .en     (1'b1),
        .ack    (I_wack),
        .done   (I_wdone),
        .req    (O_wreq),
        .state  (w_state),
        .accept (w_accept),
        .drop   (w_drop)
    );

    fbuf_chan_fsm u_rd (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .fs     (I_rfs),
        .en     (r_en),
        .ack    (I_rack),
        .done   (I_rdone),
        .req    (O_rreq),
        .state  (r_state),
        .accept (r_accept),
        .drop   (r_drop)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wbuf_q      <= LAST_IDX;
            rbuf_q      <= 2'd0;
            last_done_q <= 2'd0;
            ld_valid_q  <= 1'b0;
            hold_q      <= 1'b0;
            wdrop_q     <= 8'd0;
            rrep_q      <= 8'd0;
            O_waddr     <= addr_of(LAST_IDX);
            O_raddr     <= addr_of(2'd0);
        end else begin
            if (r_accept) begin
                rbuf_q  <= rsel;
                O_raddr <= addr_of(rsel);
                hold_q  <= 1'b1;
            end
            // Accept (IDLE) and completion (RUN) are mutually exclusive.
            if (w_accept) begin
                wbuf_q  <= wsel;
                O_waddr <= addr_of(wsel);
                if (wsel == last_done_q) ld_valid_q <= 1'b0;
            end else if (wdone_eff) begin
                last_done_q <= wbuf_q;
                ld_valid_q  <= 1'b1;
            end
            if (w_drop) wdrop_q <= wdrop_q + 8'd1;
            // Only a sync with no frame to show is a repeat; busy syncs are silent.
            if (r_drop && r_state == ST_IDLE) rrep_q <= rrep_q + 8'd1;
        end
    end

    assign O_wbuf      = wbuf_q;
    assign O_rbuf      = rbuf_q;
    assign O_wdrop_cnt = wdrop_q;
    assign O_rrep_cnt  = rrep_q;

endmodule

// File: tb/tb_fbuf_sched.sv
// Scoreboard bench for fbuf_sched: directed stimulus pushes hand-computed
// expected outputs; a monitor pops and compares them after each clock edge.
module tb_fbuf_sched;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h1080_0000;
    localparam logic [31:0] A2 = 32'h1100_0000;

    typedef struct packed {
        logic        wreq;
        logic [1:0]  wbuf;
        logic [31:0] waddr;
        logic        rreq;
        logic [1:0]  rbuf;
        logic [31:0] raddr;
        logic [7:0]  wdrop;
        logic [7:0]  rrep;
    } out_t;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_wfs = 1'b0, I_rfs = 1'b0;
    logic        I_wack = 1'b0, I_rack = 1'b0;
    logic        I_wdone = 1'b0, I_rdone = 1'b0;
    logic        O_wreq, O_rreq;
    logic [1:0]  O_wbuf, O_rbuf;
    logic [31:0] O_waddr, O_raddr;
    logic [7:0]  O_wdrop_cnt, O_rrep_cnt;

    out_t  cur;
    out_t  exp_q[$];
    int    due_q[$];
    string tag_q[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;

    fbuf_sched dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_wfs       (I_wfs),
        .I_rfs       (I_rfs),
        .I_wack      (I_wack),
        .I_rack      (I_rack),
        .I_wdone     (I_wdone),
        .I_rdone     (I_rdone),
        .O_wreq      (O_wreq),
        .O_rreq      (O_rreq),
        .O_wbuf      (O_wbuf),
        .O_rbuf      (O_rbuf),
        .O_waddr     (O_waddr),
        .O_raddr     (O_raddr),
        .O_wdrop_cnt (O_wdrop_cnt),
        .O_rrep_cnt  (O_rrep_cnt)
    );

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; the outputs after the following edge must equal cur.
    task automatic step(input logic rst, input logic wfs, input logic wack, input logic wdone,
                        input logic rfs, input logic rack, input logic rdone, input string tag);
        @(negedge I_clk);
        I_rst = rst; I_wfs = wfs; I_wack = wack; I_wdone = wdone;
        I_rfs = rfs; I_rack = rack; I_rdone = rdone;
        exp_q.push_back(cur);
        due_q.push_back(cyc + 1);
        tag_q.push_back(tag);
    endtask

    initial begin : monitor
        out_t  e;
        string t;
        forever begin
            @(posedge I_clk);
            #2;
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                void'(due_q.pop_front());
                check({t, ".wreq"},  32'(O_wreq),      32'(e.wreq));
                check({t, ".wbuf"},  32'(O_wbuf),      32'(e.wbuf));
                check({t, ".waddr"}, O_waddr,          e.waddr);
                check({t, ".rreq"},  32'(O_rreq),      32'(e.rreq));
                check({t, ".rbuf"},  32'(O_rbuf),      32'(e.rbuf));
                check({t, ".raddr"}, O_raddr,          e.raddr);
                check({t, ".wdrop"}, 32'(O_wdrop_cnt), 32'(e.wdrop));
                check({t, ".rrep"},  32'(O_rrep_cnt),  32'(e.rrep));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        cur = '{wreq: 1'b0, wbuf: 2'd2, waddr: A2, rreq: 1'b0, rbuf: 2'd0, raddr: A0,
                wdrop: 8'd0, rrep: 8'd0};
        step(1, 0,0,0, 0,0,0, "reset0");
        step(1, 0,0,0, 0,0,0, "reset1");

        cur.rrep = 8'd1;
        step(0, 0,0,0, 1,0,0, "rfs_no_frame");
        cur.wreq = 1'b1; cur.wbuf = 2'd0; cur.waddr = A0;
        step(0, 1,0,0, 0,0,0, "wfs_first");
        step(0, 0,0,0, 0,0,0, "wreq_hold");
        cur.wreq = 1'b0;
        step(0, 0,1,0, 0,0,0, "wack");
        cur.wdrop = 8'd1;
        step(0, 1,0,0, 0,0,0, "wfs_drop_run");
        step(0, 0,0,0, 0,1,1, "stray_rack");
        step(0, 0,0,1, 0,0,0, "wdone0");

        cur.rreq = 1'b1; cur.rbuf = 2'd0; cur.raddr = A0;
        step(0, 0,0,0, 1,0,0, "rfs_take0");
        cur.rreq = 1'b0;
        step(0, 0,0,0, 0,1,0, "rack");
        step(0, 0,0,0, 0,0,1, "rdone");

        cur.wreq = 1'b1; cur.wbuf = 2'd1; cur.waddr = A1;
        step(0, 1,0,0, 0,0,0, "wfs_to1");
        cur.wreq = 1'b0;
        step(0, 0,1,0, 0,0,0, "wack1");
        step(0, 0,0,1, 0,0,0, "wdone1");
        cur.wreq = 1'b1; cur.wbuf = 2'd2; cur.waddr = A2;
        step(0, 1,0,0, 0,0,0, "wfs_to2");
        cur.wreq = 1'b0;
        step(0, 0,1,0, 0,0,0, "wack2");
        step(0, 0,0,1, 0,0,0, "wdone2");

        cur.wreq = 1'b1; cur.wbuf = 2'd1; cur.waddr = A1;
        step(0, 1,0,0, 0,0,0, "wfs_skip_held0");
        cur.wreq = 1'b0;
        step(0, 0,1,0, 0,0,0, "wack3");
        cur.rreq = 1'b1; cur.rbuf = 2'd1; cur.raddr = A1;
        step(0, 0,0,1, 1,0,0, "fwd_done1_rfs");
        cur.rreq = 1'b0;
        step(0, 0,0,0, 0,1,0, "rack1");
        step(0, 0,0,0, 0,0,1, "rdone1");

        cur.wreq = 1'b1; cur.wbuf = 2'd2; cur.waddr = A2;
        step(0, 1,0,0, 0,0,0, "wfs_to2b");
        cur.wreq = 1'b0;
        step(0, 0,1,0, 0,0,0, "wack4");
        cur.rreq = 1'b1; cur.rbuf = 2'd2; cur.raddr = A2;
        step(0, 0,0,1, 1,0,0, "fwd_done2_rfs");
        cur.rreq = 1'b0;
        step(0, 0,0,0, 1,1,0, "rfs_busy_ignored");
        step(0, 0,0,0, 0,0,1, "rdone2");

        cur.wreq = 1'b1; cur.wbuf = 2'd0; cur.waddr = A0;
        step(0, 1,0,0, 0,0,0, "wfs_wrap0");
        cur.wdrop = 8'd2;
        step(0, 1,0,0, 0,0,0, "wfs_drop_req");

        cur = '{wreq: 1'b0, wbuf: 2'd2, waddr: A2, rreq: 1'b0, rbuf: 2'd0, raddr: A0,
                wdrop: 8'd0, rrep: 8'd0};
        step(1, 0,0,0, 0,0,0, "reset_mid_req");
        step(0, 0,1,1, 0,1,1, "post_reset_stray");
        cur.rrep = 8'd1;
        step(0, 0,0,0, 1,0,0, "rfs_after_reset");
        step(0, 0,0,0, 0,0,0, "drain");

        for (int i = 0; i < 10 && due_q.size() > 0; i++) @(posedge I_clk);
        #3;
        if (due_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked", due_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fbuf_sched.md
FBUF_SCHED -- requirements
Module: fbuf_sched

Interface
REQ-001 SHALL have parameters: BUF_NUM, default 3, number of frame buffers (legal 2..4); ADDR_W, default 32, address width; BUF_BASE, default 32'h1000_0000, buffer 0 base; BUF_SIZE, default 32'h0080_0000, byte stride between buffers.
REQ-002 SHALL have ports: I_clk  in  1  sole clock. One clock; reset is synchronous and active-high.
REQ-003 SHALL have ports: I_rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: I_wfs  in  1  write-side frame-sync pulse (one cycle, from fs_cap); I_rfs  in  1  read-side frame-sync pulse.
REQ-005 SHALL have ports: I_wack, I_rack  in  1  FDMA accepted request; I_wdone, I_rdone  in  1  FDMA frame complete (one-cycle pulses).
REQ-006 SHALL have ports: O_wreq, O_rreq  out  1  frame transfer request; O_wbuf, O_rbuf  out  2  buffer index; O_waddr, O_raddr  out  ADDR_W  buffer base address.
REQ-007 SHALL have ports: O_wdrop_cnt  out  8  dropped write frames; O_rrep_cnt  out  8  read frames with no new frame available.

Function
REQ-008 Write and read channels SHALL each run FSM IDLE -> REQ -> RUN -> IDLE.
REQ-009 IDLE->REQ on frame-sync pulse (read: only if a valid completed frame exists); REQ->RUN when ack=1; RUN->IDLE when done=1.
REQ-010 Req SHALL be high in REQ state only, asserted the cycle after the accepted pulse, deasserted the cycle after ack.
REQ-011 Write buffer selection on accepted I_wfs: cand=(wbuf+1) mod BUF_NUM; if read is holding cand, cand=(cand+1) mod BUF_NUM.
REQ-012 If the selected write buffer equals last_done, last_done valid SHALL clear in the same cycle.
REQ-013 On I_wdone, last_done SHALL be set to wbuf and marked valid.
REQ-014 Read selection on accepted I_rfs: rbuf=last_done; read hold flag SHALL be set and kept set until reset.
REQ-015 I_rfs in IDLE with no valid frame SHALL leave O_rbuf unchanged, keep O_rreq=0, and increment O_rrep_cnt.
REQ-016 I_wfs outside write IDLE SHALL be ignored (wbuf/state unchanged) and O_wdrop_cnt SHALL increment; I_rfs outside read IDLE SHALL be ignored without counting.
REQ-017 Counters SHALL wrap 255->0.
REQ-018 Same-cycle I_wdone and I_rfs: read SHALL select the just-completed buffer (forwarded).
REQ-019 Same-cycle I_wfs and I_rfs: read selection resolves first; write skip rule SHALL use the newly selected rbuf.
REQ-020 O_waddr/O_raddr SHALL equal BUF_BASE + index*BUF_SIZE (modulo 2^ADDR_W), registered, valid in the same cycle req rises.
REQ-021 ack or done received outside the state expecting it SHALL be ignored.

Reset
REQ-022 On I_rst=1 at a clock edge: both FSMs IDLE, O_wreq=O_rreq=0, wbuf=BUF_NUM-1, rbuf=0, last_done invalid, hold flag clear, both counters 0.
REQ-023 O_waddr/O_raddr SHALL reset to the address of their reset index.
REQ-024 Reset mid-transfer SHALL drop req on the next cycle with no further outputs changing until a new frame sync arrives.

Structure
REQ-025 A shared package SHALL hold the FSM state encodings (IDLE/REQ/RUN) and the index-to-address helper.
REQ-026 A single sub-module fbuf_chan_fsm (fs, ack, done -> req, state, accept/drop strobes) SHALL be instantiated twice; selection and counters live in fbuf_sched.

Verification (BUF_NUM=3, defaults)
REQ-027 Reset, I_wfs -> next cycle O_wbuf=0, O_waddr=32'h1000_0000, O_wreq=1; I_wack -> O_wreq=0 next cycle; I_wdone -> last_done=0 valid.
REQ-028 After reset, I_rfs before any I_wdone -> O_rreq stays 0, O_rrep_cnt=1.
REQ-029 Read holding buffer 0, wbuf=2, I_wfs -> O_wbuf=1, O_waddr=32'h1080_0000 (buffer 0 skipped).
REQ-030 I_wfs while write in RUN -> O_wbuf unchanged, O_wdrop_cnt increments by 1.
REQ-031 I_wdone (wbuf=2) and I_rfs same cycle -> next cycle O_rbuf=2, O_raddr=32'h1100_0000, O_rreq=1.
REQ-032 I_rst during O_wreq=1 -> O_wreq=0, O_wbuf=2, counters 0 next cycle.
